// File: rtl/wb_stage_pkg.sv
// Shared rv32i types for the write-back end of the pipeline: word/register
// typedefs, the regfile mux select encoding and the MEM/WB register bundle.
package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;

    typedef enum logic [3:0] {
        RFM_ALU      = 4'd0,
        RFM_BR_EN    = 4'd1,
        RFM_U_IMM    = 4'd2,
        RFM_PC_PLUS4 = 4'd3,
        RFM_LW       = 4'd4,
        RFM_LH       = 4'd5,
        RFM_LHU      = 4'd6,
        RFM_LB       = 4'd7,
        RFM_LBU      = 4'd8
    } regfilemux_sel_t;

    typedef struct packed {
        logic            valid;
        logic            load_regfile;
        regfilemux_sel_t sel;
        rv32i_reg        rd;
        rv32i_word       alu_out;
        logic            br_en;
        rv32i_word       u_imm;
        rv32i_word       pc;
        rv32i_word       rdata;
    } memwb_pipe_t;

    localparam memwb_pipe_t MEMWB_RESET = '{
        valid:        1'b0,
        load_regfile: 1'b0,
        sel:          RFM_ALU,
        rd:           5'd0,
        alu_out:      32'd0,
        br_en:        1'b0,
        u_imm:        32'd0,
        pc:           32'd0,
        rdata:        32'd0
    };

    function automatic logic is_load(input regfilemux_sel_t sel);
        return (sel == RFM_LW) || (sel == RFM_LH) || (sel == RFM_LHU) ||
               (sel == RFM_LB) || (sel == RFM_LBU);
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load extraction: picks the byte/halfword addressed by offset out of the
// aligned dcache word and sign- or zero-extends it to a full register value.
module load_align
    import rv32i_types::*;
(
    input  rv32i_word       rdata,
    input  logic [1:0]      offset,
    input  regfilemux_sel_t sel,
    output rv32i_word       load_val
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    // Halfword offset bit 0 is ignored: misaligned halfwords are not trapped.
    always_comb begin
        half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (offset)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
    end

    always_comb begin
        load_val = 32'd0;
        case (sel)
            RFM_LW:  load_val = rdata;
            RFM_LH:  load_val = {{16{half[15]}}, half};
            RFM_LHU: load_val = {16'd0, half};
            RFM_LB:  load_val = {{24{byte_v[7]}}, byte_v};
            RFM_LBU: load_val = {24'd0, byte_v};
            default: load_val = 32'd0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rv32i write-back stage: MEM/WB pipeline register, final regfile mux with
// load extension, regfile write port and a retired-instruction counter.
module wb_stage
    import rv32i_types::*;
#(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 exmem_valid,
    input  logic                 exmem_load_regfile,
    input  logic [3:0]           exmem_regfilemux_sel,
    input  logic [4:0]           exmem_rd,
    input  logic [31:0]          exmem_alu_out,
    input  logic                 exmem_br_en,
    input  logic [31:0]          exmem_u_imm,
    input  logic [31:0]          exmem_pc,
    input  logic [31:0]          mem_rdata,
    output logic                 memwb_load_regfile,
    output logic [4:0]           memwb_rd,
    output logic [31:0]          wb_regfilemux_out,
    output logic [31:0]          memwb_pc,
    output logic [INSTRET_W-1:0] instret
);

    memwb_pipe_t          pipe_q, pipe_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    rv32i_word            load_val;
    rv32i_word            mux_out;

    always_comb begin
        pipe_d = pipe_q;
        if (!stall) begin
            pipe_d.valid        = exmem_valid;
            pipe_d.load_regfile = exmem_load_regfile;
            pipe_d.sel          = regfilemux_sel_t'(exmem_regfilemux_sel);
            pipe_d.rd           = exmem_rd;
            pipe_d.alu_out      = exmem_alu_out;
            pipe_d.br_en        = exmem_br_en;
            pipe_d.u_imm        = exmem_u_imm;
            pipe_d.pc           = exmem_pc;
            pipe_d.rdata        = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= MEMWB_RESET;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // An instruction retires on the edge that moves it out of WB.
    always_comb begin
        instret_d = instret_q;
        if (pipe_q.valid && !stall) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    load_align u_load_align (
        .rdata    (pipe_q.rdata),
        .offset   (pipe_q.alu_out[1:0]),
        .sel      (pipe_q.sel),
        .load_val (load_val)
    );

    always_comb begin
        mux_out = 32'd0;
        case (pipe_q.sel)
            RFM_ALU:      mux_out = pipe_q.alu_out;
            RFM_BR_EN:    mux_out = {31'd0, pipe_q.br_en};
            RFM_U_IMM:    mux_out = pipe_q.u_imm;
            RFM_PC_PLUS4: mux_out = pipe_q.pc + 32'd4;
            default:      mux_out = is_load(pipe_q.sel) ? load_val : 32'd0;
        endcase
    end

    // Write stays asserted through a stall; the repeated write is harmless.
    assign memwb_load_regfile = pipe_q.valid && pipe_q.load_regfile && (pipe_q.rd != 5'd0);
    assign memwb_rd           = pipe_q.rd;
    assign wb_regfilemux_out  = mux_out;
    assign memwb_pc           = pipe_q.pc;
    assign instret            = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a field-level model.
module tb_wb_stage;
    import rv32i_types::*;

    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          exmem_valid = 1'b0;
    logic          exmem_load_regfile = 1'b0;
    logic [3:0]    exmem_regfilemux_sel = 4'd0;
    logic [4:0]    exmem_rd = 5'd0;
    logic [31:0]   exmem_alu_out = 32'd0;
    logic          exmem_br_en = 1'b0;
    logic [31:0]   exmem_u_imm = 32'd0;
    logic [31:0]   exmem_pc = 32'd0;
    logic [31:0]   mem_rdata = 32'd0;
    logic          memwb_load_regfile;
    logic [4:0]    memwb_rd;
    logic [31:0]   wb_regfilemux_out;
    logic [31:0]   memwb_pc;
    logic [IW-1:0] instret;

    int checks = 0;
    int errors = 0;

    // Model of the instruction currently in WB and the retire count.
    bit          m_valid, m_load, m_br;
    int unsigned m_sel;
    int unsigned m_rd;
    bit [31:0]   m_alu, m_uimm, m_pc, m_rdata;
    longint unsigned m_count;

    always #5 clk = ~clk;

    wb_stage #(.INSTRET_W(IW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .exmem_valid          (exmem_valid),
        .exmem_load_regfile   (exmem_load_regfile),
        .exmem_regfilemux_sel (exmem_regfilemux_sel),
        .exmem_rd             (exmem_rd),
        .exmem_alu_out        (exmem_alu_out),
        .exmem_br_en          (exmem_br_en),
        .exmem_u_imm          (exmem_u_imm),
        .exmem_pc             (exmem_pc),
        .mem_rdata            (mem_rdata),
        .memwb_load_regfile   (memwb_load_regfile),
        .memwb_rd             (memwb_rd),
        .wb_regfilemux_out    (wb_regfilemux_out),
        .memwb_pc             (memwb_pc),
        .instret              (instret)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [31:0] model_data();
        bit [31:0] b, h;
        b = (m_rdata >> (8 * (m_alu % 4))) & 32'hFF;
        h = (m_rdata >> (16 * ((m_alu / 2) % 2))) & 32'hFFFF;
        case (m_sel)
            0: return m_alu;
            1: return m_br ? 32'd1 : 32'd0;
            2: return m_uimm;
            3: return m_pc + 32'd4;
            4: return m_rdata;
            5: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            6: return h;
            7: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            8: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_load = 0; m_br = 0; m_sel = 0; m_rd = 0;
        m_alu = 0; m_uimm = 0; m_pc = 0; m_rdata = 0; m_count = 0;
    endtask

    task automatic check_all(input string tag);
        bit we;
        we = m_valid && m_load && (m_rd != 0);
        check({tag, ".we"},   {63'd0, memwb_load_regfile}, {63'd0, we});
        check({tag, ".rd"},   {59'd0, memwb_rd}, 64'(m_rd));
        check({tag, ".data"}, {32'd0, wb_regfilemux_out}, {32'd0, model_data()});
        check({tag, ".pc"},   {32'd0, memwb_pc}, {32'd0, m_pc});
        check({tag, ".instret"}, {56'd0, instret}, m_count % 256);
    endtask

    task automatic drive(input bit v, input bit ld, input int unsigned sel, input int unsigned rd,
                         input bit [31:0] alu, input bit br, input bit [31:0] uimm,
                         input bit [31:0] pc, input bit [31:0] rdata);
        exmem_valid = v; exmem_load_regfile = ld; exmem_regfilemux_sel = sel[3:0];
        exmem_rd = rd[4:0]; exmem_alu_out = alu; exmem_br_en = br;
        exmem_u_imm = uimm; exmem_pc = pc; mem_rdata = rdata;
    endtask

    // One clock: advance the model with what the DUT sees, then let outputs settle.
    task automatic tick();
        @(posedge clk);
        if (!stall) begin
            if (m_valid) m_count++;
            m_valid = exmem_valid; m_load = exmem_load_regfile; m_sel = exmem_regfilemux_sel;
            m_rd = exmem_rd; m_alu = exmem_alu_out; m_br = exmem_br_en;
            m_uimm = exmem_u_imm; m_pc = exmem_pc; m_rdata = mem_rdata;
        end
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
    endtask

    initial begin
        model_reset();
        #12 rst = 1'b0;
        #1;

        // Reset asserted mid-cycle with a valid instruction stalled in WB.
        drive(1, 1, 0, 7, 32'h55, 0, 0, 32'h100, 0);
        tick();
        stall = 1'b1;
        tick();
        check_all("pre_reset");
        do_reset();
        check("rst.we", {63'd0, memwb_load_regfile}, 64'd0);
        check("rst.data", {32'd0, wb_regfilemux_out}, 64'd0);
        check("rst.pc", {32'd0, memwb_pc}, 64'd0);
        check("rst.instret", {56'd0, instret}, 64'd0);
        rst = 1'b0;
        tick();
        tick();
        check_all("post_reset_hold");
        check("post_reset.rd", {59'd0, memwb_rd}, 64'd0);
        stall = 1'b0;

        // Load extension.
        drive(1, 1, 7, 5, 32'h1003, 0, 0, 32'h200, 32'h80FF7F01); tick();
        check("lb.data", {32'd0, wb_regfilemux_out}, 64'hFFFFFF80);
        check("lb.we", {63'd0, memwb_load_regfile}, 64'd1);
        check("lb.rd", {59'd0, memwb_rd}, 64'd5);
        drive(1, 1, 8, 5, 32'h1003, 0, 0, 32'h204, 32'h80FF7F01); tick();
        check("lbu.data", {32'd0, wb_regfilemux_out}, 64'h00000080);
        drive(1, 1, 5, 6, 32'h1002, 0, 0, 32'h208, 32'h80FF7F01); tick();
        check("lh2.data", {32'd0, wb_regfilemux_out}, 64'hFFFF80FF);
        drive(1, 1, 6, 6, 32'h1000, 0, 0, 32'h20C, 32'h80FF7F01); tick();
        check("lhu0.data", {32'd0, wb_regfilemux_out}, 64'h00007F01);
        drive(1, 1, 5, 6, 32'h1003, 0, 0, 32'h210, 32'h80FF7F01); tick();
        check("lh_misaligned.data", {32'd0, wb_regfilemux_out}, 64'hFFFF80FF);
        drive(1, 1, 4, 6, 32'h1003, 0, 0, 32'h214, 32'h80FF7F01); tick();
        check("lw.data", {32'd0, wb_regfilemux_out}, 64'h80FF7F01);

        // x0 suppression.
        drive(1, 1, 0, 0, 32'h1234, 0, 0, 32'h218, 0); tick();
        check("x0.we", {63'd0, memwb_load_regfile}, 64'd0);
        drive(1, 1, 0, 1, 32'h1234, 0, 0, 32'h21C, 0); tick();
        check("x1.we", {63'd0, memwb_load_regfile}, 64'd1);
        check("x1.data", {32'd0, wb_regfilemux_out}, 64'h1234);

        // BR_EN / U_IMM / undefined select.
        drive(1, 1, 1, 2, 32'hFFFF, 1, 0, 32'h220, 0); tick();
        check("br_en.data", {32'd0, wb_regfilemux_out}, 64'h1);
        drive(1, 1, 2, 2, 0, 0, 32'hABCDE000, 32'h224, 0); tick();
        check("u_imm.data", {32'd0, wb_regfilemux_out}, 64'hABCDE000);
        drive(1, 1, 12, 2, 32'h777, 1, 32'h999, 32'h228, 32'h5555); tick();
        check("undef_sel.data", {32'd0, wb_regfilemux_out}, 64'h0);

        // Stall hold with PC+4 wrap.
        drive(1, 1, 3, 3, 0, 0, 0, 32'hFFFFFFFC, 0); tick();
        check_all("pc4");
        begin
            logic [IW-1:0] held;
            held = instret;
            stall = 1'b1;
            drive(1, 1, 0, 9, 32'hDEAD, 0, 0, 32'h300, 0);
            for (int i = 0; i < 3; i++) begin
                tick();
                check("stall.data", {32'd0, wb_regfilemux_out}, 64'h0);
                check("stall.we", {63'd0, memwb_load_regfile}, 64'd1);
                check("stall.instret", {56'd0, instret}, {56'd0, held});
            end
            stall = 1'b0;
            tick();
            check("unstall.instret", {56'd0, instret}, {56'd0, held} + 64'd1);
            check_all("unstall_capture");
        end

        // Counting with bubbles.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        do_reset(); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive((i < 4 || i > 5), 1, 0, 4, i, 0, 0, 32'h400 + 4 * i, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        check("count8.instret", {56'd0, instret}, 64'd8);

        // Wrap of the 8-bit counter.
        do_reset(); rst = 1'b0;
        drive(1, 1, 0, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) tick();
        check("count255.instret", {56'd0, instret}, 64'd255);
        tick();
        check("wrap.instret", {56'd0, instret}, 64'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 15),
                  $urandom_range(0, 31), $urandom, $urandom_range(0, 1), $urandom,
                  $urandom, $urandom);
            tick();
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back end of the rv32i pipeline. Holds the MEM/WB pipeline register and selects the final register value, including load extraction and sign/zero extension.
- Drives the regfile write port consumed by decode: memwb_load_regfile, memwb_rd and wb_regfilemux_out.
- Also exports those three signals for forwarding, and keeps a retired-instruction counter.

Parameters:
- INSTRET_W, 64, width of retired-instruction counter

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  global pipeline stall; MEM/WB register holds when 1
- exmem_valid  input  1  instruction present in MEM
- exmem_load_regfile  input  1  instruction writes rd
- exmem_regfilemux_sel  input  4  regfilemux_sel_t: ALU, BR_EN, U_IMM, PC_PLUS4, LW, LH, LHU, LB, LBU
- exmem_rd  input  5  destination register
- exmem_alu_out  input  32  ALU result / load address
- exmem_br_en  input  1  compare result (SLT family)
- exmem_u_imm  input  32  U-type immediate
- exmem_pc  input  32  instruction PC
- mem_rdata  input  32  dcache read word aligned to the address, valid with exmem
- memwb_load_regfile  output  1  regfile write enable
- memwb_rd  output  5  regfile write address
- wb_regfilemux_out  output  32  regfile write data
- memwb_pc  output  32  PC of instruction in WB (debug/trace)
- instret  output  INSTRET_W  retired-instruction count

Behaviour:
- Reset (async, rst=1):
  - All MEM/WB fields clear to 0, including valid.
  - instret clears to 0.
  - Outputs are therefore 0; memwb_load_regfile=0.
- Register capture, on the rising edge of clk when stall=0:
  - Every exmem_* field is captured.
  - mem_rdata is captured.
  - memwb_valid captures exmem_valid.
- Register hold: when stall=1, all fields hold unchanged.
- Latency: one cycle from EX/MEM to WB outputs.
- Write enable: memwb_load_regfile = memwb_valid & load_regfile & (memwb_rd != 0).
  - x0 writes are always suppressed.
  - The write stays asserted during stall. The repeat write is idempotent and required for forwarding stability.
- Data select (combinational from the register):
  - ALU: alu_out.
  - BR_EN: zero-extended br_en.
  - U_IMM: u_imm.
  - PC_PLUS4: pc+4, wrapping mod 2^32.
  - LW: rdata.
  - LH/LHU: halfword rdata[16*alu_out[1] +: 16]; LH sign-extends, LHU zero-extends.
  - LB/LBU: byte rdata[8*alu_out[1:0] +: 8]; LB sign-extends, LBU zero-extends.
  - Misaligned LH with alu_out[0]=1: alu_out[0] is ignored, no trap.
  - LW ignores alu_out[1:0].
  - Undefined sel encodings drive 0.
- instret increments by 1 on a clock edge with memwb_valid=1 and stall=0. Each instruction is counted exactly once, when it leaves WB.
  - Wraps to 0 at 2^INSTRET_W.
  - Bubbles (valid=0) are not counted.
- Simultaneous stall deassert and new capture: the old WB instruction is counted and the new one is loaded on the same edge.
- Reset mid-stall: reset wins, and the pending instruction is dropped uncounted.

Decomposition:
- Shared package rv32i_types holds:
  - regfilemux_sel_t enum (4-bit);
  - rv32i_word and rv32i_reg typedefs;
  - a memwb_pipe_t struct bundling the captured fields.
- Sub-module load_align: purely combinational; takes rdata, offset[1:0] and sel, and returns the extended load value.

Test Plan:
- Reset: assert rst mid-cycle with valid data -> all outputs 0 immediately and instret=0; release -> outputs stay 0 until the first capture.
- Load extension: exmem LB, alu_out=0x1003, rdata=0x80FF7F01, rd=5 -> next cycle wb_regfilemux_out=0xFFFFFF80, memwb_load_regfile=1, memwb_rd=5. Same with LBU -> 0x00000080. LH offset 2 -> 0xFFFF80FF. LHU offset 0 -> 0x00007F01.
- x0 suppression: ALU op, rd=0, alu_out=0x1234 -> memwb_load_regfile=0. Same with rd=1 -> 1 and data 0x1234.
- Stall hold: capture PC_PLUS4 at pc=0xFFFFFFFC, then stall for 3 cycles -> data=0x00000000 stable all 3 cycles, write enable held, instret unchanged until stall drops, then +1.
- Counting: stream 4 valid instrs, 2 bubbles, 4 valid -> instret=8. Preload near the max value for INSTRET_W=8 (255) + 1 retire -> 0.
- BR_EN/U_IMM: br_en=1 -> 0x00000001; U_IMM 0xABCDE000 -> 0xABCDE000.
